// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding and widths for the FIR MAC sequencer
package fir_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, MAC, DONE} seq_state_t;
  localparam int NTAPS_DEFAULT = 16;
  localparam int TAP_ADDR_W_DEFAULT = 4;
  typedef logic [TAP_ADDR_W_DEFAULT-1:0] tap_addr_t;
endpackage

// File: rtl/edge_detect.sv
// edge_detect: registered rising-edge detector for level strobes
module edge_detect (
  input  logic ck,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic q;
  always_ff @(posedge ck or negedge rst)
    if (!rst) q <= 1'b0;
    else q <= d;
  assign rise = d & ~q;
endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: one-MAC FIR sequencer; FIR_MAC_SEQUENCER_PENDING_EN queues one busy-time strobe
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS  = NTAPS_DEFAULT,
  parameter int ADDR_W = TAP_ADDR_W_DEFAULT
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              input_ready,
  output logic              sample_we,
  output logic [ADDR_W-1:0] sample_addr,
  output logic [ADDR_W-1:0] coeff_addr,
  output logic              acc_clear,
  output logic              acc_en,
  output logic              out_load,
  output logic              output_ready,
  output logic              busy,
  output logic              overrun
);
  seq_state_t state, state_n;
  logic [ADDR_W-1:0] wr_ptr, k, sa_q, ca_q;
  logic strobe, go, lost, last_tap;
  edge_detect u_edge (
    .ck  (ck),
    .rst (rst),
    .d   (input_ready),
    .rise(strobe)
  );
  assign last_tap = k == ADDR_W'(NTAPS - 1);
`ifdef FIR_MAC_SEQUENCER_PENDING_EN
  logic pending;
  // an edge during the IDLE cycle that consumes pending takes its place
  always_ff @(posedge ck or negedge rst)
    if (!rst) pending <= 1'b0;
    else pending <= busy ? (pending | strobe) : (pending & strobe);
  assign go   = strobe | pending;
  assign lost = strobe & busy & pending;
`else
  assign go   = strobe;
  assign lost = strobe & busy;
`endif
  always_ff @(posedge ck or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE  ? (go ? WRITE : IDLE) :
              state == WRITE ? MAC :
              state == MAC   ? (last_tap ? DONE : MAC) : IDLE;
  end
  always_comb begin
    busy        = state != IDLE;
    sample_we   = state == WRITE;
    acc_en      = state == MAC;
    acc_clear   = acc_en && k == '0;
    out_load    = state == DONE;
    sample_addr = sample_we ? wr_ptr : acc_en ? wr_ptr - k : sa_q;
    coeff_addr  = acc_en ? k : ca_q;
  end
  always_ff @(posedge ck or negedge rst)
    if (!rst) begin
      wr_ptr       <= '0;
      k            <= '0;
      sa_q         <= '0;
      ca_q         <= '0;
      output_ready <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr + ADDR_W'(state == DONE);
      k            <= state == MAC ? k + 1'b1 : '0;
      sa_q         <= sample_addr;
      ca_q         <= coeff_addr;
      output_ready <= state == DONE;
      overrun      <= overrun | lost;
    end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: randomized check against a schedule-offset reference model
`timescale 1ns/1ps
module tb_fir_mac_sequencer;
  localparam int NTAPS = 16;
`ifdef FIR_MAC_SEQUENCER_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif
  logic ck = 1'b0, rst = 1'b0, input_ready = 1'b0;
  logic sample_we, acc_clear, acc_en, out_load, output_ready, busy, overrun;
  logic [3:0] sample_addr, coeff_addr;
  fir_mac_sequencer #(.NTAPS(NTAPS), .ADDR_W(4)) dut (
    .ck          (ck),
    .rst         (rst),
    .input_ready (input_ready),
    .sample_we   (sample_we),
    .sample_addr (sample_addr),
    .coeff_addr  (coeff_addr),
    .acc_clear   (acc_clear),
    .acc_en      (acc_en),
    .out_load    (out_load),
    .output_ready(output_ready),
    .busy        (busy),
    .overrun     (overrun)
  );
  always #5 ck = ~ck;
  int checks = 0, failures = 0;
  int c = 0, s = 0;
  bit act = 0, pend = 0, ovr = 0, ir_prev = 0;
  logic [3:0] ptr = 0;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, 16'({busy, sample_we, acc_en, acc_clear, out_load, output_ready, overrun}), 16'd0);
    chk({tag, "_addr"}, 16'({sample_addr, coeff_addr}), 16'd0);
  endtask
  task automatic model_reset();
    act = 0; pend = 0; ovr = 0; ir_prev = 0; ptr = 0;
  endtask
  // offset d = cycles since the accepted edge: 1 write, 2..17 taps, 18 load, 19 ready
  task automatic step(input bit ir);
    int d;
    bit e, idle;
    @(negedge ck);
    d = act ? c - s : -1;
    chk("ctrl", 16'({busy, sample_we, acc_en, acc_clear, out_load, output_ready, overrun}),
        16'({d >= 1 && d <= 18, d == 1, d >= 2 && d <= 17, d == 2, d == 18, d == 19, ovr}));
    if (d == 1) chk("write_addr", 16'(sample_addr), 16'(ptr));
    if (d >= 2 && d <= 17) begin
      chk("read_addr", 16'(sample_addr), 16'((int'(ptr) - (d - 2)) & (NTAPS - 1)));
      chk("coeff_addr", 16'(coeff_addr), 16'(d - 2));
    end
    input_ready = ir;
    e = ir & ~ir_prev;
    ir_prev = ir;
    idle = !act || d >= 19;
    if (d == 18) ptr = ptr + 1;
    if (idle && (e || pend)) begin
      act = 1; s = c; pend = pend & e;
    end else if (e && !idle) begin
      if (PEND && !pend) pend = 1;
      else ovr = 1;
    end
    c++;
  endtask
  task automatic strobe(input int width, input int gap);
    for (int i = 0; i < width; i++) step(1'b1);
    for (int i = 0; i < gap; i++) step(1'b0);
  endtask
  initial begin
    #1 chk_zero("reset");
    #9 rst = 1'b1;
    #1 chk_zero("post_reset");
    for (int i = 0; i < 5; i++) step(1'b0);
    strobe(1, 30);
    for (int i = 0; i < 17; i++) strobe(1, 24);
    strobe(5, 30);
    // reset in the middle of the tap loop, at k=7
    strobe(1, 9);
    #2 rst = 1'b0;
    #1 chk_zero("mid_reset");
    model_reset();
    @(negedge ck);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0);
    strobe(1, 30);
    strobe(1, 4);
    strobe(1, 4);
    strobe(1, 50);
    for (int n = 0; n < 40; n++) strobe($urandom_range(1, 5), $urandom_range(1, 30));
    for (int i = 0; i < 45; i++) step(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Sequencer for a time-multiplexed FIR datapath built from one multiply-accumulate unit, a circular sample RAM and a coefficient ROM. It detects the sample strobe `input_ready` (40 kHz strobe, 1 MHz `ck`) and writes the new sample into the RAM. It then steps the MAC through all taps and loads the datapath output register, finishing with an `output_ready` pulse. It replaces a fully parallel FIR: the `fir` top instantiates this block beside the MAC datapath.

Parameters:
- NTAPS, 16: number of filter taps; must be a power of two, at least 2.
- ADDR_W, 4: address width, equal to log2(NTAPS).

Ports:
- `ck`  input  1  system clock.
- `rst`  input  1  asynchronous active-low reset.
- `input_ready`  input  1  sample strobe, level ≥1 cycle; rising edge = new sample.
- `sample_we`  output  1  sample RAM write enable.
- `sample_addr`  output  ADDR_W  sample RAM address (write or read).
- `coeff_addr`  output  ADDR_W  coefficient ROM address.
- `acc_clear`  output  1  with acc_en: accumulator loads the product instead of adding it.
- `acc_en`  output  1  MAC accumulate enable.
- `out_load`  output  1  datapath output register load.
- `output_ready`  output  1  one-cycle pulse: new output valid.
- `busy`  output  1  high whenever state ≠ IDLE.
- `overrun`  output  1  sticky: a strobe edge was lost.

Behaviour:
- Reset (`rst`=0, asynchronous, any state):
  - state=IDLE, wr_ptr=0, tap counter=0, edge register=0, pending=0.
  - All outputs 0.
  - Reset mid-sequence abandons that sample; no output_ready is produced for it.
- Edge detect: ir_q <= input_ready; edge = input_ready & ~ir_q. A level held high gives exactly one edge.
- FSM states: IDLE, WRITE, MAC, DONE.
  - IDLE -> WRITE on edge (or on pending, see Optional Feature).
  - WRITE (1 cycle): sample_we=1, sample_addr=wr_ptr. Then -> MAC with k=0.
  - MAC (NTAPS cycles, k=0..NTAPS-1):
    - acc_en=1, coeff_addr=k, sample_addr=(wr_ptr-k) mod NTAPS (natural ADDR_W wrap).
    - acc_clear=1 only at k=0.
    - After k=NTAPS-1 -> DONE.
  - DONE (1 cycle): out_load=1, wr_ptr <= wr_ptr+1 (wraps NTAPS-1 -> 0). Then -> IDLE.
- output_ready: registered, 1 in the cycle after DONE, otherwise 0.
- Latency, with edge in cycle N:
  - WRITE at N+1.
  - MAC at N+2 .. N+NTAPS+1.
  - DONE at N+NTAPS+2.
  - output_ready at N+NTAPS+3.
  - Total NTAPS+3 = 19 cycles, well inside the 25-cycle sample period.
- Outputs outside their stated states are 0.
  - sample_addr and coeff_addr hold their last value; they are don't-care when unused.
- overrun: set by an edge that cannot be accepted; cleared only by reset.
- Edge arriving in the same cycle as DONE is a busy-time edge. It is handled per the Optional Feature and is never accepted directly into WRITE.

Optional Feature:
- Macro: FIR_MAC_SEQUENCER_PENDING_EN.
- Defined:
  - A one-deep pending flag is set by an edge while busy.
  - On entering IDLE with pending=1, the FSM goes to WRITE on the next cycle and clears pending.
  - An edge while busy with pending already 1 sets overrun.
- Undefined:
  - No pending flag exists.
  - Any edge while busy is dropped and sets overrun.

Decomposition:
- Package fir_pkg holds:
  - typedef enum logic [1:0] {IDLE, WRITE, MAC, DONE} seq_state_t;
  - localparam NTAPS_DEFAULT=16;
  - typedef logic [ADDR_W-1:0] tap_addr_t (ADDR_W default 4).
- One natural sub-module: edge_detect (registered rising-edge detector), reusable for other strobes.
- The FSM, counters and pointer stay in fir_mac_sequencer.

Test Plan:
- Reset/idle: rst=0 for 10 ns, then 1 -> all outputs 0 and busy=0 until the first edge.
- Single strobe, input_ready high 1 cycle at cycle N:
  - sample_we=1 with addr 0 at N+1.
  - 16 acc_en cycles with coeff_addr 0..15 and sample_addr 0,15,14..1.
  - acc_clear only at N+2.
  - out_load at N+18, output_ready at N+19.
- Wrap: 17 strobes every 25 cycles -> on the 17th sample, sample_we addr=0 again; sample_addr sequence on the 16th sample is 15,14..0; overrun stays 0.
- Long level: input_ready held high 5 cycles -> exactly one sequence and one output_ready pulse.
- Busy strobe (second edge 5 cycles after the first):
  - With PENDING_EN: second WRITE starts at cycle N+20, overrun=0. A third edge while pending sets overrun=1.
  - Without PENDING_EN: second edge dropped, overrun=1.
- Reset mid-MAC: rst=0 at k=7 -> outputs 0 immediately, no output_ready; the next strobe writes addr 0.
